// File: rtl/load_align_unit.sv
// Load alignment unit: queues outstanding dmem loads in order, extracts and extends the
// addressed byte/halfword/word from each returned word, and registers the result for writeback.
module load_align_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RD_W  = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [1:0]      i_req_pos,
    input  logic [RD_W-1:0] i_req_rd,
    input  logic            i_dmem_rvalid,
    output logic            o_dmem_rready,
    input  logic [31:0]     i_dmem_rdata,
    output logic            o_ld_valid,
    input  logic            i_ld_ready,
    output logic [31:0]     o_ld_data,
    output logic [RD_W-1:0] o_ld_rd,
    output logic            o_ld_fault,
    output logic            o_busy,
    output logic            o_spurious
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Queue storage
    logic [2:0]      funct3_q [DEPTH];
    logic [1:0]      pos_q    [DEPTH];
    logic [RD_W-1:0] rd_q     [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Output register
    logic            ld_valid_q, ld_valid_d;
    logic [31:0]     ld_data_q, ld_data_d;
    logic [RD_W-1:0] ld_rd_q, ld_rd_d;
    logic            ld_fault_q, ld_fault_d;
    logic            spurious_q, spurious_d;

    logic push;
    logic pop;
    logic queue_empty;
    logic queue_full;

    logic [2:0]      head_funct3;
    logic [1:0]      head_pos;
    logic [RD_W-1:0] head_rd;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ext_data;
    logic            ext_fault;

    assign queue_empty = (count_q == '0);
    assign queue_full  = (count_q == DEPTH_C);

    assign o_req_ready   = !queue_full;
    assign o_dmem_rready = !queue_empty && (!ld_valid_q || i_ld_ready);

    // Count is evaluated before the edge, so a same-cycle push never satisfies this rvalid.
    assign push = i_req_valid && o_req_ready;
    assign pop  = i_dmem_rvalid && o_dmem_rready;

    assign head_funct3 = funct3_q[rd_ptr_q];
    assign head_pos    = pos_q[rd_ptr_q];
    assign head_rd     = rd_q[rd_ptr_q];

    // Lane selection and extension for the entry at the head of the queue
    always_comb begin
        byte_sel = 8'h00;
        unique case (head_pos)
            2'b00: byte_sel = i_dmem_rdata[7:0];
            2'b01: byte_sel = i_dmem_rdata[15:8];
            2'b10: byte_sel = i_dmem_rdata[23:16];
            2'b11: byte_sel = i_dmem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = head_pos[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    end

    always_comb begin
        ext_data  = 32'h0;
        ext_fault = 1'b0;
        case (head_funct3)
            F3_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: ext_data = {24'h0, byte_sel};
            F3_LH: begin
                if (head_pos[0]) begin
                    ext_fault = 1'b1;
                end else begin
                    ext_data = {{16{half_sel[15]}}, half_sel};
                end
            end
            F3_LHU: begin
                if (head_pos[0]) begin
                    ext_fault = 1'b1;
                end else begin
                    ext_data = {16'h0, half_sel};
                end
            end
            F3_LW: begin
                if (head_pos != 2'b00) begin
                    ext_fault = 1'b1;
                end else begin
                    ext_data = i_dmem_rdata;
                end
            end
            default: ext_fault = 1'b1;
        endcase
    end

    // Queue pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output register next state; contents persist after handshake until the next pop.
    always_comb begin
        ld_valid_d = ld_valid_q;
        ld_data_d  = ld_data_q;
        ld_rd_d    = ld_rd_q;
        ld_fault_d = ld_fault_q;
        spurious_d = spurious_q;
        if (pop) begin
            ld_valid_d = 1'b1;
            ld_data_d  = ext_data;
            ld_rd_d    = head_rd;
            ld_fault_d = ext_fault;
        end else if (ld_valid_q && i_ld_ready) begin
            ld_valid_d = 1'b0;
        end
        if (i_dmem_rvalid && queue_empty) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
            ld_rd_q    <= '0;
            ld_fault_q <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
            ld_rd_q    <= ld_rd_d;
            ld_fault_q <= ld_fault_d;
            spurious_q <= spurious_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (push) begin
            funct3_q[wr_ptr_q] <= i_req_funct3;
            pos_q[wr_ptr_q]    <= i_req_pos;
            rd_q[wr_ptr_q]     <= i_req_rd;
        end
    end

    assign o_ld_valid = ld_valid_q;
    assign o_ld_data  = ld_data_q;
    assign o_ld_rd    = ld_rd_q;
    assign o_ld_fault = ld_fault_q;
    assign o_busy     = !queue_empty || ld_valid_q;
    assign o_spurious = spurious_q;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Read-side counterpart of the store byte-mask logic. Tracks outstanding data-memory loads in order, takes each returned 32-bit word, and extracts the addressed byte, halfword or word. Sign- or zero-extends per funct3 and hands the result to writeback through a valid/ready register.
- Sits between the dmem read-data port and the register-file writeback mux.

Parameters:
DEPTH, 2, outstanding-load queue entries (power of two, >= 2)
RD_W, 5, destination register index width

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_req_valid  input  1  load issued to dmem this cycle
o_req_ready  output  1  queue can accept a load
i_req_funct3  input  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
i_req_pos  input  2  address bits [1:0]
i_req_rd  input  RD_W  destination register
i_dmem_rvalid  input  1  dmem returns a word
o_dmem_rready  output  1  unit consumes the returned word this cycle
i_dmem_rdata  input  32  returned word, little-endian byte lanes
o_ld_valid  output  1  result held in output register
i_ld_ready  input  1  writeback accepts result
o_ld_data  output  32  extended load result
o_ld_rd  output  RD_W  destination of result
o_ld_fault  output  1  misaligned or illegal funct3 for this result
o_busy  output  1  queue non-empty or o_ld_valid
o_spurious  output  1  sticky: rvalid seen with empty queue

Behaviour:
- Reset (i_rst=1 at an edge): queue count, pointers and o_ld_valid go to 0. o_ld_data, o_ld_rd, o_ld_fault and o_spurious go to 0. Reset mid-operation discards all pending loads and any held result.
- o_req_ready = (count != DEPTH). Push when i_req_valid & o_req_ready; store {funct3, pos, rd}. When full, a push is refused even if a pop occurs in the same cycle.
- o_dmem_rready = (count != 0) & (!o_ld_valid | i_ld_ready). Pop occurs when i_dmem_rvalid & o_dmem_rready.
  - The popped head entry plus i_dmem_rdata load the output register at that edge.
  - o_ld_valid=1 on the next cycle: one-cycle latency, rdata registered.
- Data memory holds rvalid/rdata until rready. Responses return strictly in request order.
- Empty-queue rvalid: it is not consumed, and o_spurious is set and held until reset. A request pushed in the same cycle is never matched by that cycle's rvalid, because count is evaluated before the edge.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Output register: o_ld_valid clears when i_ld_ready & o_ld_valid and no new pop occurs. Back-to-back pop with i_ld_ready keeps o_ld_valid=1 with new contents.
- Extraction:
  - LB/LBU select byte pos: 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
  - LH/LHU select [15:0] when pos[1]=0, [31:16] when pos[1]=1.
  - LB/LH sign-extend from the selected MSB. LBU/LHU zero-extend. LW passes the word.
- Fault:
  - LH/LHU with pos[0]=1, LW with pos!=00, or funct3 in {011,110,111} -> o_ld_data=0 and o_ld_fault=1. The entry is still popped and the result is still delivered with its rd.
  - Otherwise o_ld_fault=0.
- o_busy = (count != 0) | o_ld_valid.

Test Plan:
- LB, pos=11, rdata=0x80FF_1234, i_ld_ready=1 -> one cycle after pop: o_ld_valid=1, o_ld_data=0xFFFF_FF80, o_ld_fault=0.
- LHU, pos=10, rdata=0x9ABC_5678 -> o_ld_data=0x0000_9ABC. Then LH with the same data -> 0xFFFF_9ABC.
- LW, pos=01, rd=7 -> o_ld_fault=1, o_ld_data=0, o_ld_rd=7, and the queue entry is still consumed.
- Issue DEPTH loads without responses -> o_req_ready=0 and a further i_req_valid is ignored. Return the words in order -> results carry rd values in issue order, and o_busy drops after the last handshake.
- Hold i_ld_ready=0 with o_ld_valid=1 and rvalid=1 pending -> o_dmem_rready=0 and the result stays stable. Raise i_ld_ready -> the pending word pops in that cycle and the next result appears the following cycle.
- rvalid=1 with an empty queue -> o_spurious=1 and it stays set. Assert i_rst mid-stream with 2 loads pending -> the next cycle has count=0, o_ld_valid=0 and o_spurious=0.
